// File: rtl/space_pkg.sv
// -----------------------------------------------------------------------------
// space_pkg
// Shared definitions for the space-shooter blocks: screen dimensions, colour
// codes used by the pixel mixers, the move-FSM state encoding, the move
// direction type, and the button index map used by the ship input sequencer.
// -----------------------------------------------------------------------------
package space_pkg;

    // Screen geometry (visible area).
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Colour codes driven into the pixel mixer.
    localparam logic [2:0] COL_BACKGROUND = 3'd0;
    localparam logic [2:0] COL_SPACESHIP  = 3'd1;
    localparam logic [2:0] COL_ALIENS0    = 3'd2;
    localparam logic [2:0] COL_ALIENS1    = 3'd3;
    localparam logic [2:0] COL_ALIENS2    = 3'd4;
    localparam logic [2:0] COL_ALIENS3    = 3'd5;
    localparam logic [2:0] COL_LASER      = 3'd6;
    localparam logic [2:0] COL_NONE       = 3'd7;

    // Button positions inside the packed button vectors.
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_FIRE  = 2;
    localparam int BTN_COUNT = 3;

    // Move FSM states. FIRST/REPEAT are used with auto-repeat, HELD without.
    typedef enum logic [1:0] {
        MV_IDLE   = 2'd0,
        MV_FIRST  = 2'd1,
        MV_REPEAT = 2'd2,
        MV_HELD   = 2'd3
    } move_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_e;

    // Exactly one direction held gives that direction; both or neither is none.
    function automatic dir_e held_dir(input logic l, input logic r);
        if (l && !r) begin
            return DIR_L;
        end else if (r && !l) begin
            return DIR_R;
        end
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/ship_ctrl_sched_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-FF synchroniser, stability counter and rising-edge press detector for
// one raw push button.
//
// Ports:
//   clk      in  clock
//   reset    in  synchronous, active-high reset
//   btn_i    in  raw asynchronous button level (active-high)
//   level_o  out debounced button level
//   press_o  out one-cycle pulse, high in the first cycle level_o reads 1
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_MAX = 250000,
    parameter int DEBOUNCE_W   = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_MAX - 1);

    logic                  sync1_q, sync2_q;
    logic                  level_q, level_d;
    logic                  press_q, press_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

    // The counter only survives while the synchronised input disagrees with
    // the accepted level; any agreeing cycle restarts the stability window.
    // The level flips on the DEBOUNCE_MAX-th consecutive disagreeing cycle.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/ship_ctrl_sched.sv
// -----------------------------------------------------------------------------
// ship_ctrl_sched
// Player-ship input sequencer. Debounces the three buttons, turns held
// left/right buttons into frame-aligned single-cycle move pulses, and grants
// fire requests against the laser busy flag and a shot cooldown. All
// decisions are taken on the start-of-blanking frame tick, so outputs assert
// on the cycle after frame_tick.
//
// Build option:
//   SHIP_AUTOREPEAT_EN  defined   -> held direction auto-repeats
//                                    (FIRST_DELAY frames, then every
//                                    REPEAT_PERIOD frames)
//                       undefined -> one move pulse per debounced press
//
// Ports:
//   clk         in   pixel clock
//   reset       in   synchronous, active-high reset
//   btn_left    in   raw left button
//   btn_right   in   raw right button
//   btn_fire    in   raw fire button
//   hPos        in   [9:0] current pixel column
//   vPos        in   [9:0] current pixel line
//   laser_busy  in   laser shot in flight (sampled on tick cycles only)
//   left        out  one-cycle move-left pulse
//   right       out  one-cycle move-right pulse
//   fire        out  one-cycle shot-launch pulse
//   frame_tick  out  one-cycle start-of-blanking strobe
// -----------------------------------------------------------------------------
module ship_ctrl_sched
    import space_pkg::*;
#(
    parameter int SCREEN_HEIGHT = SCREEN_H,
    parameter int DEBOUNCE_MAX  = 250000,
    parameter int DEBOUNCE_W    = 18,
    parameter int FIRST_DELAY   = 15,
    parameter int REPEAT_PERIOD = 6,
    parameter int FIRE_COOLDOWN = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    input  logic       laser_busy,
    output logic       left,
    output logic       right,
    output logic       fire,
    output logic       frame_tick
);

    localparam int CNT_MAX = (FIRST_DELAY > REPEAT_PERIOD) ? FIRST_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CD_W    = $clog2(FIRE_COOLDOWN + 1);
    localparam logic [9:0] TICK_LINE = 10'(SCREEN_HEIGHT);

    // ---------------------------------------------------------------- buttons
    logic [BTN_COUNT-1:0] btn_raw;
    logic [BTN_COUNT-1:0] btn_level;
    logic [BTN_COUNT-1:0] btn_press;

    assign btn_raw = {btn_fire, btn_right, btn_left};

    for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_MAX (DEBOUNCE_MAX),
            .DEBOUNCE_W   (DEBOUNCE_W)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (btn_raw[gi]),
            .level_o (btn_level[gi]),
            .press_o (btn_press[gi])
        );
    end

    // ---------------------------------------------------------------- state
    logic                frame_tick_q, frame_tick_d;
    move_state_e         mv_state_q, mv_state_d;
    dir_e                dir_q, dir_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                fire_pend_q, fire_pend_d;
    logic [CD_W-1:0]     cooldown_q, cooldown_d;
    logic                left_q, left_d;
    logic                right_q, right_d;
    logic                fire_q, fire_d;

    // A press arriving in the very cycle of a tick is masked out of this
    // tick's direction so it is first seen on the following tick.
    dir_e dir_now;
    assign dir_now = held_dir(btn_level[BTN_LEFT]  & ~btn_press[BTN_LEFT],
                              btn_level[BTN_RIGHT] & ~btn_press[BTN_RIGHT]);

    always_comb begin
        frame_tick_d = (hPos == 10'd0) && (vPos == TICK_LINE);
        mv_state_d   = mv_state_q;
        dir_d        = dir_q;
        frame_cnt_d  = frame_cnt_q;
        fire_pend_d  = fire_pend_q;
        cooldown_d   = cooldown_q;
        left_d       = 1'b0;
        right_d      = 1'b0;
        fire_d       = 1'b0;

        if (frame_tick_q) begin
            // ---- move FSM
            unique case (mv_state_q)
                MV_IDLE: begin
                    if (dir_now != DIR_NONE) begin
                        left_d      = (dir_now == DIR_L);
                        right_d     = (dir_now == DIR_R);
                        dir_d       = dir_now;
                        frame_cnt_d = CNT_W'(FIRST_DELAY - 1);
`ifdef SHIP_AUTOREPEAT_EN
                        mv_state_d  = MV_FIRST;
`else
                        mv_state_d  = MV_HELD;
`endif
                    end
                end
                MV_FIRST, MV_REPEAT, MV_HELD: begin
                    // dir_q is never NONE here, so this also catches release
                    // and both-held.
                    if (dir_now != dir_q) begin
                        mv_state_d = MV_IDLE;
                    end else if (frame_cnt_q != '0) begin
                        frame_cnt_d = frame_cnt_q - 1'b1;
                    end
`ifdef SHIP_AUTOREPEAT_EN
                    else begin
                        left_d      = (dir_q == DIR_L);
                        right_d     = (dir_q == DIR_R);
                        frame_cnt_d = CNT_W'(REPEAT_PERIOD - 1);
                        mv_state_d  = MV_REPEAT;
                    end
`endif
                end
                default: mv_state_d = MV_IDLE;
            endcase

            // ---- fire arbiter (cooldown counts ticks, saturating at 0)
            if (fire_pend_q && !laser_busy && (cooldown_q == '0)) begin
                fire_d      = 1'b1;
                fire_pend_d = 1'b0;
                cooldown_d  = CD_W'(FIRE_COOLDOWN);
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - 1'b1;
            end
        end

        // A new press re-arms the request even on a grant cycle; releasing
        // the button before the grant withdraws it.
        if (btn_press[BTN_FIRE]) begin
            fire_pend_d = 1'b1;
        end else if (!btn_level[BTN_FIRE]) begin
            fire_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
            mv_state_q   <= MV_IDLE;
            dir_q        <= DIR_NONE;
            frame_cnt_q  <= '0;
            fire_pend_q  <= 1'b0;
            cooldown_q   <= '0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            fire_q       <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
            mv_state_q   <= mv_state_d;
            dir_q        <= dir_d;
            frame_cnt_q  <= frame_cnt_d;
            fire_pend_q  <= fire_pend_d;
            cooldown_q   <= cooldown_d;
            left_q       <= left_d;
            right_q      <= right_d;
            fire_q       <= fire_d;
        end
    end

    assign left       = left_q;
    assign right      = right_q;
    assign fire       = fire_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ship_ctrl_sched.sv
// -----------------------------------------------------------------------------
// tb_ship_ctrl_sched
// Directed bench for ship_ctrl_sched with a short frame (8 columns x 6 lines,
// tick on line 4). Expected move/fire pulses are queued per future tick by the
// stimulus; a negedge monitor predicts frame_tick from the driven position and
// compares every output every cycle. Expectations follow SHIP_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_ship_ctrl_sched;

    localparam int SH    = 4;
    localparam int H_TOT = 8;
    localparam int V_TOT = 6;

    logic       clk;
    logic       reset;
    logic       btn_left, btn_right, btn_fire;
    logic [9:0] hPos, vPos;
    logic       laser_busy;
    logic       left, right, fire, frame_tick;

    ship_ctrl_sched #(
        .SCREEN_HEIGHT (SH),
        .DEBOUNCE_MAX  (4),
        .DEBOUNCE_W    (3),
        .FIRST_DELAY   (3),
        .REPEAT_PERIOD (2),
        .FIRE_COOLDOWN (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_fire   (btn_fire),
        .hPos       (hPos),
        .vPos       (vPos),
        .laser_busy (laser_busy),
        .left       (left),
        .right      (right),
        .fire       (fire),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic l;
        logic r;
        logic f;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   out_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect (l,r,f) on the k-th tick from now.
    task automatic push(input int k, input logic l, input logic r, input logic f);
        exp_t e;
        e.idx = out_count + k;
        e.l = l;
        e.r = r;
        e.f = f;
        q.push_back(e);
    endtask

    // Return just after the next output cycle (early in a frame).
    task automatic next_frame_start();
        int start;
        start = out_count;
        for (int i = 0; i < 200 && out_count == start; i++) @(posedge clk);
        check("frame_wait_timeout", 32'(out_count != start), 32'd1);
        if (out_count == start) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $fatal(1, "FAIL frame_wait: no frame tick within bound");
        end
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) next_frame_start();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------- frame model
    initial begin
        hPos = '0;
        vPos = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hPos == 10'(H_TOT - 1)) begin
                hPos = '0;
                vPos = (vPos == 10'(V_TOT - 1)) ? 10'd0 : vPos + 10'd1;
            end else begin
                hPos = hPos + 10'd1;
            end
        end
    end

    // ---------------------------------------------------------- monitor
    logic cond_prev = 1'b0;
    logic rst_prev = 1'b1;
    logic ft_exp_prev = 1'b0;
    logic exp_ft, out_cyc;
    exp_t e_cur, e_drop;
    int   cur;

    always @(negedge clk) begin
        exp_ft  = cond_prev && !rst_prev;
        out_cyc = ft_exp_prev && !rst_prev;
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
        if (out_cyc) begin
            cur = out_count + 1;
            while (q.size() > 0 && q[0].idx < cur) begin
                e_drop = q.pop_front();
                check("sb_skipped_tick", e_drop.idx, cur);
            end
            e_cur.idx = cur;
            e_cur.l = 1'b0;
            e_cur.r = 1'b0;
            e_cur.f = 1'b0;
            if (q.size() > 0 && q[0].idx == cur) e_cur = q.pop_front();
            $display("tick %0d: left=%b right=%b fire=%b expect %b%b%b",
                     cur, left, right, fire, e_cur.l, e_cur.r, e_cur.f);
            check("left_tick", 32'(left), 32'(e_cur.l));
            check("right_tick", 32'(right), 32'(e_cur.r));
            check("fire_tick", 32'(fire), 32'(e_cur.f));
            out_count = cur;
        end else begin
            check("left_idle", 32'(left), 32'd0);
            check("right_idle", 32'(right), 32'd0);
            check("fire_idle", 32'(fire), 32'd0);
        end
        ft_exp_prev = exp_ft;
        cond_prev   = (hPos == 10'd0) && (vPos == 10'(SH));
        rst_prev    = reset;
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        reset      = 1'b1;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_fire   = 1'b0;
        laser_busy = 1'b0;
        cycles(5);
        reset = 1'b0;

        // 1. bouncing left never debounces
        next_frame_start();
        for (int i = 0; i < 5; i++) begin
            btn_left = 1'b1;
            cycles(2);
            btn_left = 1'b0;
            cycles(2);
        end
        wait_ticks(2);

        // 2. hold left for 8 frames
        btn_left = 1'b1;
        push(1, 1'b1, 1'b0, 1'b0);
`ifdef SHIP_AUTOREPEAT_EN
        push(4, 1'b1, 1'b0, 1'b0);
        push(6, 1'b1, 1'b0, 1'b0);
        push(8, 1'b1, 1'b0, 1'b0);
`endif
        wait_ticks(8);
        btn_left = 1'b0;
        wait_ticks(1);

        // 3. both held: no motion; release right -> left on next tick
        btn_left  = 1'b1;
        btn_right = 1'b1;
        wait_ticks(5);
        btn_right = 1'b0;
        push(1, 1'b1, 1'b0, 1'b0);
        wait_ticks(1);
        btn_left = 1'b0;
        wait_ticks(1);

        // 4. fire blocked by busy for 2 ticks, granted on the 3rd
        btn_fire   = 1'b1;
        laser_busy = 1'b1;
        push(3, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        laser_busy = 1'b0;
        wait_ticks(1);
        // re-press: held off by 3 ticks of cooldown, granted on the 4th
        btn_fire = 1'b0;
        cycles(10);
        btn_fire = 1'b1;
        push(4, 1'b0, 1'b0, 1'b1);
        wait_ticks(4);
        btn_fire = 1'b0;
        wait_ticks(1);

        // 5. press + release while busy withdraws the request
        laser_busy = 1'b1;
        btn_fire   = 1'b1;
        cycles(10);
        btn_fire = 1'b0;
        cycles(10);
        laser_busy = 1'b0;
        wait_ticks(5);

        // 6. reset during repeat with a pending shot
        btn_left   = 1'b1;
        btn_fire   = 1'b1;
        laser_busy = 1'b1;
        push(1, 1'b1, 1'b0, 1'b0);
`ifdef SHIP_AUTOREPEAT_EN
        push(4, 1'b1, 1'b0, 1'b0);
`endif
        wait_ticks(4);
        cycles(5);
        reset = 1'b1;
        cycles(3);
        reset      = 1'b0;
        laser_busy = 1'b0;
        push(1, 1'b1, 1'b0, 1'b1);
`ifdef SHIP_AUTOREPEAT_EN
        push(4, 1'b1, 1'b0, 1'b0);
`endif
        wait_ticks(4);
        btn_left = 1'b0;
        btn_fire = 1'b0;
        wait_ticks(2);

        check("scoreboard_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
